wide_compare_lsw_serial: RTL and testbench

//  Word-serial magnitude comparator for wide Kaliski operands (u, v, p up to NWORDS*W bits).

---
 rtl/kaliski_pkg.sv | 27 ++
 rtl/compare_32bit.sv | 20 ++
 rtl/wide_compare_lsw_serial.sv | 130 +++++++++++++
 tb/tb_wide_compare_lsw_serial.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kaliski_pkg.sv
// Shared types for the Kaliski operand datapath: compare FSM states,
// the eq/gt/lt verdict record and the default word width.
package kaliski_pkg;

    localparam int DEFAULT_W = 32;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } cmp_state_e;

    typedef struct packed {
        logic eq;
        logic gt;
        logic lt;
    } cmp_res_t;

    // Verdict with lt derived from the other two flags.
    function automatic cmp_res_t make_res(input logic eq, input logic gt);
        cmp_res_t r;
        r.eq = eq;
        r.gt = gt;
        r.lt = ~eq & ~gt;
        return r;
    endfunction

endpackage

// File: rtl/compare_32bit.sv
// Combinational single-word magnitude compare (unsigned).
module compare_32bit
    import kaliski_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output cmp_res_t     res
);

    // One-hot eq/gt/lt of a against b.
    always_comb begin
        res    = '0;
        res.eq = (a == b);
        res.gt = (a > b);
        res.lt = (a < b);
    end

endmodule

// File: rtl/wide_compare_lsw_serial.sv
// Word-serial wide magnitude comparator. Operand words arrive LSW first;
// each unequal word overrides whatever the lower words decided, so the
// running flags after the final (most significant) word give the verdict.
module wide_compare_lsw_serial
    import kaliski_pkg::*;
#(
    parameter int W      = DEFAULT_W,
    parameter int NWORDS = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         res_valid,
    input  logic         res_ready,
    output logic         res_eq,
    output logic         res_gt,
    output logic         res_lt
);

    localparam int CW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NWORDS - 1);

    cmp_state_e    state_q,     state_d;
    logic [CW-1:0] count_q,     count_d;
    logic          run_eq_q,    run_eq_d;
    logic          run_gt_q,    run_gt_d;
    logic          res_valid_q, res_valid_d;
    cmp_res_t      res_q,       res_d;

    cmp_res_t      slice_res;
    logic          upd_eq;
    logic          upd_gt;
    logic          accept;

    compare_32bit #(.W(W)) u_slice (
        .a   (in_a),
        .b   (in_b),
        .res (slice_res)
    );

    // Running flags after folding in the current word: equal words pass
    // the lower-word decision through, unequal words replace it.
    always_comb begin
        upd_eq = run_eq_q & slice_res.eq;
        upd_gt = run_gt_q;
        if (slice_res.gt) begin
            upd_gt = 1'b1;
        end else if (slice_res.lt) begin
            upd_gt = 1'b0;
        end
    end

    // Next-state and register updates; flush overrides everything.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        run_eq_d    = run_eq_q;
        run_gt_d    = run_gt_q;
        res_valid_d = res_valid_q;
        res_d       = res_q;
        accept      = 1'b0;

        if (flush) begin
            state_d     = ACCUM;
            count_d     = '0;
            run_eq_d    = 1'b1;
            run_gt_d    = 1'b0;
            res_valid_d = 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    accept = in_valid;
                    if (accept) begin
                        if (count_q == LAST) begin
                            res_d       = make_res(upd_eq, upd_gt);
                            res_valid_d = 1'b1;
                            state_d     = HOLD;
                            count_d     = '0;
                            run_eq_d    = 1'b1;
                            run_gt_d    = 1'b0;
                        end else begin
                            count_d  = count_q + CW'(1);
                            run_eq_d = upd_eq;
                            run_gt_d = upd_gt;
                        end
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid_d = 1'b0;
                        state_d     = ACCUM;
                    end
                end
                default: begin
                    state_d = ACCUM;
                end
            endcase
        end
    end

    // State and datapath registers, cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            count_q     <= '0;
            run_eq_q    <= 1'b1;
            run_gt_q    <= 1'b0;
            res_valid_q <= 1'b0;
            res_q       <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            run_eq_q    <= run_eq_d;
            run_gt_q    <= run_gt_d;
            res_valid_q <= res_valid_d;
            res_q       <= res_d;
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign res_valid = res_valid_q;
    assign res_eq    = res_q.eq;
    assign res_gt    = res_q.gt;
    assign res_lt    = res_q.lt;

endmodule

// File: tb/tb_wide_compare_lsw_serial.sv
// Bench for wide_compare_lsw_serial (W=32, NWORDS=4): table vectors,
// hand-written flush/stall/reset sequences, and a random run against a
// 128-bit unsigned compare model, all checked through a verdict queue.
module tb_wide_compare_lsw_serial;

    localparam int W  = 32;
    localparam int NW = 4;
    localparam int TW = W * NW;

    typedef struct packed {
        logic eq;
        logic gt;
        logic lt;
    } exp_t;

    typedef struct {
        logic [TW-1:0] a;
        logic [TW-1:0] b;
        exp_t          exp;
    } vec_t;

    logic         clk;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         res_valid;
    logic         res_ready;
    logic         res_eq;
    logic         res_gt;
    logic         res_lt;

    int   checks;
    int   failures;
    exp_t exp_q[$];
    bit   rr_rand;
    bit   rr_force;

    wide_compare_lsw_serial #(.W(W), .NWORDS(NW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_eq    (res_eq),
        .res_gt    (res_gt),
        .res_lt    (res_lt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [TW-1:0] a, input logic [TW-1:0] b);
        exp_t e;
        e.eq = (a == b);
        e.gt = (a > b);
        e.lt = (a < b);
        return e;
    endfunction

    // Consumer handshake pattern: random stalls or a forced level.
    always @(posedge clk) begin
        #1;
        res_ready = rr_rand ? ($urandom_range(0, 2) != 0) : rr_force;
    end

    // Output monitor: one-hot check and scoreboard pop on each handshake.
    always @(negedge clk) begin
        if (rst_n && res_valid) begin
            chk("onehot", {res_eq, res_gt, res_lt} == 3'b100 || {res_eq, res_gt, res_lt} == 3'b010
                          || {res_eq, res_gt, res_lt} == 3'b001, 1'b1);
            if (res_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_verdict", 1'b1, 1'b0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("verdict", {res_eq, res_gt, res_lt}, e);
                    $display("verdict eq=%0b gt=%0b lt=%0b expected=%03b", res_eq, res_gt, res_lt, e);
                end
            end
        end
    end

    // Send one operand pair LSW first; gap_pct>0 inserts random idle cycles.
    task automatic send_op(input logic [TW-1:0] a, input logic [TW-1:0] b,
                           input exp_t e, input int gap_pct);
        for (int w = 0; w < NW; w++) begin
            bit acc;
            bit acc_now;
            int cyc;
            acc = 1'b0;
            cyc = 0;
            while (!acc) begin
                if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                    in_valid = 1'b0;
                end else begin
                    in_valid = 1'b1;
                end
                in_a = a[w*W +: W];
                in_b = b[w*W +: W];
                @(negedge clk);
                acc_now = in_valid && in_ready && !flush;
                @(posedge clk);
                #1;
                acc = acc_now;
                cyc++;
                if (cyc > 200) begin
                    chk("accept_timeout", 1'b1, 1'b0);
                    in_valid = 1'b0;
                    return;
                end
            end
        end
        in_valid = 1'b0;
        exp_q.push_back(e);
        chk("latency_res_valid", res_valid, 1'b1);
    endtask

    // Drive n raw beats (used for partial scans before flush/reset).
    task automatic raw_beats(input int n, input logic [W-1:0] a, input logic [W-1:0] b);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_a     = a;
            in_b     = b;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int cyc;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("drain_queue_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[8];

    initial begin
        checks   = 0;
        failures = 0;
        rr_rand  = 1'b0;
        rr_force = 1'b1;
        rst_n    = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        res_ready = 1'b1;

        tbl[0] = '{128'h00000004_00000003_00000002_00000001, 128'h00000004_00000003_00000002_00000001, 3'b100};
        tbl[1] = '{128'h00000004_00000003_00000002_00000005, 128'h00000004_00000003_00000002_00000003, 3'b010};
        tbl[2] = '{128'h80000000_00000003_00000002_00000003, 128'h7FFFFFFF_00000003_00000002_00000005, 3'b010};
        tbl[3] = '{128'h00000000_00000003_00000002_00000001, 128'hFFFFFFFF_00000003_00000002_00000001, 3'b001};
        tbl[4] = '{128'h0, 128'h0, 3'b100};
        tbl[5] = '{{TW{1'b1}}, {{(TW-1){1'b1}}, 1'b0}, 3'b010};
        tbl[6] = '{128'h00000009_00000009_00000009_00000001, 128'h00000009_00000009_00000009_00000002, 3'b001};
        tbl[7] = '{128'h00000000_00000001_00000009_00000000, 128'h00000000_00000002_00000001_00000000, 3'b001};

        // Reset state.
        #12;
        chk("reset_in_ready", in_ready, 1'b1);
        chk("reset_res_valid", res_valid, 1'b0);
        chk("reset_res_flags", {res_eq, res_gt, res_lt}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table vectors, back-to-back beats.
        for (int i = 0; i < 8; i++) begin
            $display("table vector %0d", i);
            send_op(tbl[i].a, tbl[i].b, tbl[i].exp, 0);
            drain();
        end

        // Consumer stall: verdict and in_ready held for 5 cycles.
        rr_force = 1'b0;
        send_op(tbl[3].a, tbl[3].b, tbl[3].exp, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_res_valid", res_valid, 1'b1);
            chk("hold_in_ready", in_ready, 1'b0);
            chk("hold_flags", {res_eq, res_gt, res_lt}, 3'b001);
        end
        rr_force = 1'b1;
        drain();

        // Flush after two beats of a scan; the flush-cycle beat is dropped.
        raw_beats(2, 32'h1, 32'h2);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_a     = 32'h1;
        in_b     = 32'h2;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_res_valid", res_valid, 1'b0);
        chk("flush_in_ready", in_ready, 1'b1);
        send_op(tbl[0].a, tbl[0].b, tbl[0].exp, 0);
        drain();

        // Flush while a verdict is being held discards it.
        rr_force = 1'b0;
        send_op(tbl[1].a, tbl[1].b, tbl[1].exp, 0);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        exp_q.delete();
        chk("flush_hold_res_valid", res_valid, 1'b0);
        chk("flush_hold_in_ready", in_ready, 1'b1);
        rr_force = 1'b1;
        send_op(tbl[2].a, tbl[2].b, tbl[2].exp, 0);
        drain();

        // Async reset in HOLD.
        rr_force = 1'b0;
        send_op(tbl[1].a, tbl[1].b, tbl[1].exp, 0);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("rst_hold_res_valid", res_valid, 1'b0);
        chk("rst_hold_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n    = 1'b1;
        rr_force = 1'b1;
        @(posedge clk);
        #1;

        // Async reset mid-scan, then a full scan must be correct.
        raw_beats(2, 32'h5, 32'h9);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_scan_res_valid", res_valid, 1'b0);
        chk("rst_scan_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_op(tbl[0].a, tbl[0].b, tbl[0].exp, 0);
        drain();

        // Random operand pairs with input gaps and consumer stalls.
        rr_rand = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            logic [TW-1:0] a;
            logic [TW-1:0] b;
            for (int w = 0; w < NW; w++) begin
                a[w*W +: W] = $urandom();
                case ($urandom_range(0, 3))
                    0:       b[w*W +: W] = $urandom();
                    1:       b[w*W +: W] = a[w*W +: W] + W'($urandom_range(0, 1) ? 1 : -1);
                    default: b[w*W +: W] = a[w*W +: W];
                endcase
            end
            send_op(a, b, model(a, b), 25);
        end
        rr_rand  = 1'b0;
        rr_force = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
